// File: rtl/encoder_pri_pkg.sv
// Shared constants and helpers for the clocked priority encoder/arbiter.
package encoder_pri_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/encoder_pri_arb_priority_finder.sv
// Combinational search for the highest set bit of a vector; index and found flag.
module priority_finder
  import encoder_pri_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // Ascending scan: the last hit, i.e. the highest index, is what remains.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_pri_arb.sv
// Sticky-pending priority encoder with valid/ack handshake, fixed or round-robin grant,
// and 74148-style cascade pins (EI/EO/GS, all active-low).
module encoder_pri_arb
  import encoder_pri_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = clog2(N)
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic [N-1:0] iData,
  input  logic         iEI,
  input  logic         iAck,
  output logic [W-1:0] oData,
  output logic         oValid,
  output logic         oGS,
  output logic         oEO
);

  logic [N-1:0] r_pend;
  logic [W-1:0] w_idx;
  logic         w_found;
  logic         w_accept;
  logic [N-1:0] w_clr;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [W-1:0] r_ptr;
      logic [N-1:0] w_mask;
      logic [W-1:0] w_idx_m;
      logic [W-1:0] w_idx_u;
      logic         w_found_m;

      always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
          w_mask[i] = (W'(i) <= r_ptr);
        end
      end

      priority_finder #(.N(N)) u_find_masked (
        .i_vec   (r_pend & w_mask),
        .o_idx   (w_idx_m),
        .o_found (w_found_m)
      );

      priority_finder #(.N(N)) u_find_all (
        .i_vec   (r_pend),
        .o_idx   (w_idx_u),
        .o_found (w_found)
      );

      // Nothing at or below ptr means the search wraps to the top of the vector.
      assign w_idx = w_found_m ? w_idx_m : w_idx_u;

      // The line just granted drops to lowest priority.
      always_ff @(posedge iClk) begin
        if (!iRst_n) begin
          r_ptr <= W'(N - 1);
        end else if (w_accept) begin
          r_ptr <= (w_idx == '0) ? W'(N - 1) : w_idx - 1'b1;
        end
      end
    end else begin : g_fixed
      priority_finder #(.N(N)) u_find (
        .i_vec   (r_pend),
        .o_idx   (w_idx),
        .o_found (w_found)
      );
    end
  endgenerate

  assign oValid   = ~iEI & w_found;
  assign oData    = oValid ? w_idx : '0;
  assign oGS      = ~oValid;
  assign oEO      = iEI | w_found;
  assign w_accept = iAck & oValid;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N; i++) begin
      w_clr[i] = w_accept && (w_idx == W'(i));
    end
  end

  // New requests are OR-ed in after the clear, so a line still held low survives its own ack.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_pend <= '0;
    end else if (!iEI) begin
      r_pend <= (r_pend & ~w_clr) | ~iData;
    end
  end

endmodule

// File: tb/tb_encoder_pri_arb.sv
// Bench for encoder_pri_arb: fixed N=8, round-robin N=8 and fixed N=5 instances under shared stimulus.
module tb_encoder_pri_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data8;
  logic [4:0] data5;
  logic       ei;
  logic       ack;

  logic [2:0] fx_data, rr_data, n5_data;
  logic       fx_valid, fx_gs, fx_eo;
  logic       rr_valid, rr_gs, rr_eo;
  logic       n5_valid, n5_gs, n5_eo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encoder_pri_arb #(.N(8), .MODE(0)) u_fix (
    .iClk(clk), .iRst_n(rst_n), .iData(data8), .iEI(ei), .iAck(ack),
    .oData(fx_data), .oValid(fx_valid), .oGS(fx_gs), .oEO(fx_eo)
  );

  encoder_pri_arb #(.N(8), .MODE(1)) u_rr (
    .iClk(clk), .iRst_n(rst_n), .iData(data8), .iEI(ei), .iAck(ack),
    .oData(rr_data), .oValid(rr_valid), .oGS(rr_gs), .oEO(rr_eo)
  );

  encoder_pri_arb #(.N(5), .MODE(0)) u_n5 (
    .iClk(clk), .iRst_n(rst_n), .iData(data5), .iEI(ei), .iAck(ack),
    .oData(n5_data), .oValid(n5_valid), .oGS(n5_gs), .oEO(n5_eo)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set as a bit vector, grant found by a plain search.
  int         m_n    [3] = '{8, 8, 5};
  int         m_mode [3] = '{0, 1, 0};
  logic [7:0] m_pend [3];
  int         m_ptr  [3];
  bit         m_live = 1'b0;

  function automatic int m_grant(input logic [7:0] p, input int n, input int mode, input int ptr);
    if (mode == 0) begin
      for (int i = n - 1; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) begin
        int j;
        j = (ptr - k + n) % n;
        if (p[j]) return j;
      end
    end
    return 0;
  endfunction

  function automatic bit m_any(input logic [7:0] p);
    return p != 8'h00;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic [7:0] req;
      logic [7:0] nmask;
      logic [7:0] clr;
      int         g;
      bit         v;
      nmask = (d == 2) ? 8'h1F : 8'hFF;
      req   = (d == 2) ? (~{3'b000, data5} & nmask) : ~data8;
      if (!rst_n) begin
        m_pend[d] = 8'h00;
        m_ptr[d]  = m_n[d] - 1;
      end else if (!ei) begin
        v   = m_any(m_pend[d]);
        g   = m_grant(m_pend[d], m_n[d], m_mode[d], m_ptr[d]);
        clr = (ack && v) ? (8'h01 << g) : 8'h00;
        m_pend[d] = (m_pend[d] & ~clr) | req;
        if (m_mode[d] == 1 && ack && v) m_ptr[d] = (g == 0) ? m_n[d] - 1 : g - 1;
      end
    end
    if (!rst_n) m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      int  ed[3];
      bit  ev[3];
      int  ad[3];
      bit  av[3];
      bit  ag[3];
      bit  ae[3];
      ad = '{int'(fx_data), int'(rr_data), int'(n5_data)};
      av = '{fx_valid, rr_valid, n5_valid};
      ag = '{fx_gs, rr_gs, n5_gs};
      ae = '{fx_eo, rr_eo, n5_eo};
      for (int d = 0; d < 3; d++) begin
        ev[d] = !ei && m_any(m_pend[d]);
        ed[d] = ev[d] ? m_grant(m_pend[d], m_n[d], m_mode[d], m_ptr[d]) : 0;
        chk($sformatf("model_data[%0d]", d), ad[d], ed[d]);
        chk($sformatf("model_valid[%0d]", d), int'(av[d]), int'(ev[d]));
        chk($sformatf("model_gs[%0d]", d), int'(ag[d]), int'(!ev[d]));
        chk($sformatf("model_eo[%0d]", d), int'(ae[d]), int'(ei || m_any(m_pend[d])));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_fix[4] = '{7, 4, 1, 0};
    int exp_rr5[4] = '{7, 5, 7, 5};

    // Reset with active requests and ack present
    rst_n = 1'b0; ei = 1'b0; data8 = 8'h00; data5 = 5'h1F; ack = 1'b1;
    tick();
    chk("rst_valid", int'(fx_valid), 0);
    chk("rst_data", int'(fx_data), 0);
    chk("rst_gs", int'(fx_gs), 1);
    chk("rst_eo", int'(fx_eo), 0);
    chk("rst_rr_valid", int'(rr_valid), 0);

    // Fixed order drain
    rst_n = 1'b1; data8 = 8'b01101100;
    tick();
    data8 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fixed_order_%0d", i), int'(fx_data), exp_fix[i]);
      chk($sformatf("fixed_order_v%0d", i), int'(fx_valid), 1);
      tick();
    end
    chk("fixed_drained_valid", int'(fx_valid), 0);
    chk("fixed_drained_eo", int'(fx_eo), 0);

    // Disable: no capture, outputs suppressed, pending retained
    ack = 1'b0; ei = 1'b1; data8 = 8'h00;
    repeat (3) begin
      tick();
      chk("dis_valid", int'(fx_valid), 0);
      chk("dis_eo", int'(fx_eo), 1);
    end
    ei = 1'b0; data8 = 8'hFF;
    tick();
    chk("dis_nocapture_valid", int'(fx_valid), 0);
    data8 = 8'b11110111;
    tick();
    chk("pend3_data", int'(fx_data), 3);
    data8 = 8'hFF; ei = 1'b1;
    tick();
    chk("pend3_dis_valid", int'(fx_valid), 0);
    chk("pend3_dis_data", int'(fx_data), 0);
    chk("pend3_dis_gs", int'(fx_gs), 1);
    chk("pend3_dis_eo", int'(fx_eo), 1);
    ei = 1'b0;
    #1;
    chk("pend3_reen_data", int'(fx_data), 3);
    chk("pend3_reen_valid", int'(fx_valid), 1);
    ack = 1'b1;
    tick();
    chk("pend3_acked_valid", int'(fx_valid), 0);

    // Set beats clear
    data8 = 8'b11011111;
    repeat (4) begin
      tick();
      chk("setwins_data", int'(fx_data), 5);
      chk("setwins_valid", int'(fx_valid), 1);
    end
    data8 = 8'hFF;
    tick();
    chk("setwins_released", int'(fx_valid), 0);

    // Round-robin vs fixed with the same held requests
    data8 = 8'b01011111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_grant_%0d", i), int'(rr_data), exp_rr5[i]);
      chk($sformatf("fix_grant_%0d", i), int'(fx_data), 7);
    end
    data8 = 8'hFF;
    tick();

    // Mid-operation reset restores ptr to N-1
    ack = 1'b0; data8 = 8'b11110011;
    tick();
    ack = 1'b1; rst_n = 1'b0;
    tick();
    chk("midrst_valid", int'(fx_valid), 0);
    chk("midrst_data", int'(fx_data), 0);
    chk("midrst_rr_valid", int'(rr_valid), 0);
    rst_n = 1'b1; ack = 1'b0; data8 = 8'b10111110;
    tick();
    chk("midrst_rr_ptr_top", int'(rr_data), 6);
    chk("midrst_fix", int'(fx_data), 6);

    // Odd N: top code is N-1
    data8 = 8'hFF; data5 = 5'b01111;
    tick();
    chk("n5_data", int'(n5_data), 4);
    chk("n5_valid", int'(n5_valid), 1);
    data5 = 5'b11110; ack = 1'b1;
    tick();
    chk("n5_next", int'(n5_data), 0);
    data5 = 5'h1F;
    repeat (4) tick();
    chk("n5_drained", int'(n5_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
